// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the registered ALU.
package alu_pipe_pkg;

   localparam logic [5:0] OP_ADD     = 6'h00;
   localparam logic [5:0] OP_ADDINC  = 6'h02;
   localparam logic [5:0] OP_INCA    = 6'h03;
   localparam logic [5:0] OP_SUB     = 6'h04;
   localparam logic [5:0] OP_SUBDEC  = 6'h05;
   localparam logic [5:0] OP_DECA    = 6'h06;
   localparam logic [5:0] OP_PASSB   = 6'h09;
   localparam logic [5:0] OP_ASL     = 6'h0D;
   localparam logic [5:0] OP_ASR     = 6'h0E;
   localparam logic [5:0] OP_ZEROS   = 6'h0F;
   localparam logic [5:0] OP_ONES    = 6'h10;
   localparam logic [5:0] OP_PASSA   = 6'h11;
   localparam logic [5:0] OP_NOTA    = 6'h12;
   localparam logic [5:0] OP_AND     = 6'h13;
   localparam logic [5:0] OP_ANDNOTA = 6'h14;
   localparam logic [5:0] OP_NAND    = 6'h15;
   localparam logic [5:0] OP_OR      = 6'h16;
   localparam logic [5:0] OP_ORNOTA  = 6'h17;
   localparam logic [5:0] OP_NOR     = 6'h18;
   localparam logic [5:0] OP_XOR     = 6'h19;
   localparam logic [5:0] OP_XORNOTA = 6'h1A;
   localparam logic [5:0] OP_XNOR    = 6'h1B;
   localparam logic [5:0] OP_LSL     = 6'h1C;
   localparam logic [5:0] OP_LSR     = 6'h1D;
   localparam logic [5:0] OP_ASLN    = 6'h20;
   localparam logic [5:0] OP_ASRN    = 6'h21;
   localparam logic [5:0] OP_LSLN    = 6'h22;
   localparam logic [5:0] OP_LSRN    = 6'h23;

   localparam int FLG_V       = 0;
   localparam int FLG_ZERO    = 1;
   localparam int FLG_NEG     = 2;
   localparam int FLG_NEGZERO = 3;
   localparam int FLG_TRUE    = 4;
   localparam int FLG_C       = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   function automatic logic is_multi_shift(input logic [5:0] op);
      return (op == OP_ASLN) || (op == OP_ASRN) || (op == OP_LSLN) || (op == OP_LSRN);
   endfunction

   // Multi-bit shifts are executed as repeated single-bit shifts of the same kind.
   function automatic logic [5:0] step_op(input logic [5:0] op);
      case (op)
         OP_ASLN: return OP_ASL;
         OP_ASRN: return OP_ASR;
         OP_LSLN: return OP_LSL;
         default: return OP_LSR;
      endcase
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, flags and illegal decode for every single-cycle op,
// which also serves as the one-bit step for the multi-bit shifts.
module alu_core
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [5:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_o,
   output logic [5:0]       flags_o,
   output logic             flag_we_o,
   output logic             illegal_o
);

   localparam logic [WIDTH:0]   ONE  = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0] sum;
   logic           c, v, z, sa, sb;

   assign sa = a_i[WIDTH-1];
   assign sb = b_i[WIDTH-1];

   always_comb begin
      sum       = '0;
      res_o     = '0;
      c         = 1'b0;
      v         = 1'b0;
      flag_we_o = 1'b1;
      illegal_o = 1'b0;
      case (op_i)
         OP_ADD, OP_ADDINC: begin
            sum   = {1'b0, a_i} + {1'b0, b_i} + ((op_i == OP_ADDINC) ? ONE : '0);
            res_o = sum[WIDTH-1:0];
            c     = sum[WIDTH];
            v     = (sa == sb) && (sum[WIDTH-1] != sa);
         end
         OP_SUB, OP_SUBDEC: begin
            // Bit WIDTH of the widened difference is the borrow.
            sum   = {1'b0, a_i} - {1'b0, b_i} - ((op_i == OP_SUBDEC) ? ONE : '0);
            res_o = sum[WIDTH-1:0];
            c     = sum[WIDTH];
            v     = (sa != sb) && (sum[WIDTH-1] != sa);
         end
         OP_INCA: begin
            sum   = {1'b0, a_i} + ONE;
            res_o = sum[WIDTH-1:0];
            c     = sum[WIDTH];
            v     = (a_i == SMAX);
         end
         OP_DECA: begin
            sum   = {1'b0, a_i} - ONE;
            res_o = sum[WIDTH-1:0];
            c     = sum[WIDTH];
            v     = (a_i == SMIN);
         end
         OP_PASSB: begin
            res_o     = b_i;
            flag_we_o = 1'b0;
         end
         OP_ASL: begin
            res_o = {a_i[WIDTH-2:0], 1'b0};
            c     = a_i[WIDTH-1];
            v     = a_i[WIDTH-1] ^ a_i[WIDTH-2];
         end
         OP_ASR: begin
            res_o = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
            c     = a_i[0];
         end
         OP_LSL: begin
            res_o = {a_i[WIDTH-2:0], 1'b0};
            c     = a_i[WIDTH-1];
         end
         OP_LSR: begin
            res_o = {1'b0, a_i[WIDTH-1:1]};
            c     = a_i[0];
         end
         OP_ZEROS:   res_o = '0;
         OP_ONES:    res_o = '1;
         OP_PASSA:   res_o = a_i;
         OP_NOTA:    res_o = ~a_i;
         OP_AND:     res_o = a_i & b_i;
         OP_ANDNOTA: res_o = ~a_i & b_i;
         OP_NAND:    res_o = ~(a_i & b_i);
         OP_OR:      res_o = a_i | b_i;
         OP_ORNOTA:  res_o = ~a_i | b_i;
         OP_NOR:     res_o = ~(a_i | b_i);
         OP_XOR:     res_o = a_i ^ b_i;
         OP_XORNOTA: res_o = ~a_i ^ b_i;
         OP_XNOR:    res_o = ~(a_i ^ b_i);
         // Multi-bit shifts by zero: operand passes through, C and V clear.
         OP_ASLN, OP_ASRN, OP_LSLN, OP_LSRN: res_o = a_i;
         default: begin
            flag_we_o = 1'b0;
            illegal_o = 1'b1;
         end
      endcase
      z       = (res_o == '0);
      flags_o = {c, !z, z | res_o[WIDTH-1], res_o[WIDTH-1], z, v};
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; multi-bit shifts iterate one bit
// per cycle through the core while the input side is stalled.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [5:0]       flags,
   output logic             illegal
);

   state_e             state_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic [WIDTH-1:0]   work_q, result_q;
   logic [5:0]         shop_q, flags_q;
   logic               vacc_q, illegal_q;

   logic               accept, shifting;
   logic [SHAMT_W-1:0] amt;
   logic [5:0]         core_op, core_flags, step_flags_d;
   logic [WIDTH-1:0]   core_a, core_res;
   logic               core_we, core_ill;

   assign shifting  = (state_q == S_SHIFT);
   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign amt       = b[SHAMT_W-1:0];
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign flags     = flags_q;
   assign illegal   = illegal_q;

   // While shifting, the core steps the work register instead of the live inputs.
   assign core_op = shifting ? shop_q : op;
   assign core_a  = shifting ? work_q : a;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op_i      (core_op),
      .a_i       (core_a),
      .b_i       (b),
      .res_o     (core_res),
      .flags_o   (core_flags),
      .flag_we_o (core_we),
      .illegal_o (core_ill)
   );

   // V is sticky across shift steps: any sign change along the way counts.
   always_comb begin
      step_flags_d        = core_flags;
      step_flags_d[FLG_V] = core_flags[FLG_V] | vacc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         shop_q    <= OP_LSR;
         vacc_q    <= 1'b0;
         result_q  <= '0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            S_SHIFT: begin
               work_q <= core_res;
               vacc_q <= step_flags_d[FLG_V];
               cnt_q  <= cnt_q - SHAMT_W'(1);
               if (cnt_q == SHAMT_W'(1)) begin
                  state_q   <= S_DONE;
                  result_q  <= core_res;
                  flags_q   <= step_flags_d;
                  illegal_q <= 1'b0;
               end
            end
            default: begin
               if (accept) begin
                  if (is_multi_shift(op) && (amt != '0)) begin
                     state_q <= S_SHIFT;
                     cnt_q   <= amt;
                     work_q  <= a;
                     shop_q  <= step_op(op);
                     vacc_q  <= 1'b0;
                  end else begin
                     state_q   <= S_DONE;
                     result_q  <= core_res;
                     illegal_q <= core_ill;
                     if (core_we) flags_q <= core_flags;
                  end
               end else if ((state_q == S_DONE) && out_ready) begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: expectations queued at issue, compared when the result appears.
module tb_alu_pipe;
   import alu_pipe_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic [5:0]  flg;
      logic        ill;
      int          busy;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [5:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        in_ready, out_valid, illegal;
   logic [31:0] result;
   logic [5:0]  flags;

   int          total = 0, bad = 0;
   logic [5:0]  model_flags = '0;
   exp_t        sb[$];

   localparam longint MAXL = 64'sd2147483647;
   localparam longint MINL = -64'sd2147483648;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .illegal   (illegal)
   );

   function automatic exp_t mk(input logic [31:0] r, input logic [5:0] f, input logic il, input int bz);
      exp_t e;
      e.res = r; e.flg = f; e.ill = il; e.busy = bz;
      return e;
   endfunction

   // Reference behaviour written directly from the op definitions, using wide arithmetic.
   function automatic exp_t model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t               e;
      logic [32:0]        w;
      longint             sr;
      logic signed [31:0] t;
      int                 n;
      logic               c, v, keep, z;
      n = int'(y[4:0]);
      c = 1'b0; v = 1'b0; keep = 1'b0;
      e.res = '0; e.ill = 1'b0; e.busy = 0;
      case (o)
         OP_ADD: begin
            w = {1'b0, x} + {1'b0, y}; e.res = w[31:0]; c = w[32];
            sr = longint'($signed(x)) + longint'($signed(y)); v = (sr > MAXL) || (sr < MINL);
         end
         OP_SUB: begin
            e.res = x - y; c = (x < y);
            sr = longint'($signed(x)) - longint'($signed(y)); v = (sr > MAXL) || (sr < MINL);
         end
         OP_INCA:   begin e.res = x + 32'd1; c = (x == 32'hFFFF_FFFF); v = (x == 32'h7FFF_FFFF); end
         OP_DECA:   begin e.res = x - 32'd1; c = (x == 32'h0);         v = (x == 32'h8000_0000); end
         OP_PASSB:  begin e.res = y; keep = 1'b1; end
         OP_AND:    e.res = x & y;
         OP_XOR:    e.res = x ^ y;
         OP_ORNOTA: e.res = ~x | y;
         OP_ASL:    begin e.res = x << 1; c = x[31]; v = (x[31] != x[30]); end
         OP_LSR:    begin e.res = x >> 1; c = x[0]; end
         OP_ASRN, OP_LSRN: begin
            t = $signed(x) >>> n;
            e.res = (o == OP_ASRN) ? 32'(t) : (x >> n);
            if (n != 0) c = x[n-1];
            e.busy = n;
         end
         OP_LSLN, OP_ASLN: begin
            e.res = x << n;
            if (n != 0) c = x[32-n];
            t = $signed(x << n);
            if (o == OP_ASLN) v = ((t >>> n) != $signed(x));
            e.busy = n;
         end
         default: begin keep = 1'b1; e.ill = 1'b1; end
      endcase
      z = (e.res == 32'h0);
      e.flg = keep ? model_flags : {c, !z, z | e.res[31], e.res[31], z, v};
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic send(input string tag, input logic [5:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input exp_t e);
      int n = 0;
      op = o; a = av; b = bv; in_valid = 1'b1;
      while (!in_ready && n < 50) begin tick(); n++; end
      if (n == 50) check({tag, "/accept_timeout"}, 64'(n), 64'(0));
      sb.push_back(e);
      model_flags = e.flg;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic collect(input string tag);
      exp_t e;
      int   busy = 0;
      logic rdy_seen = 1'b0;
      while (!out_valid && busy < 100) begin
         if (in_ready) rdy_seen = 1'b1;
         a = $urandom; b = $urandom;
         tick(); busy++;
      end
      check({tag, "/sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check({tag, "/busy"}, 64'(busy), 64'(e.busy));
      check({tag, "/result"}, 64'(result), 64'(e.res));
      check({tag, "/flags"}, 64'(flags), 64'(e.flg));
      check({tag, "/illegal"}, 64'(illegal), 64'(e.ill));
      if (e.busy > 0) check({tag, "/in_ready_busy"}, 64'(rdy_seen), 64'(0));
      tick();
   endtask

   task automatic run(input string tag, input logic [5:0] o, input logic [31:0] av, input logic [31:0] bv);
      send(tag, o, av, bv, model(o, av, bv));
      collect(tag);
   endtask

   initial begin
      exp_t ex, ey;
      logic ov_seen;

      tick(); tick();
      check("rst/out_valid", 64'(out_valid), 64'(0));
      check("rst/result", 64'(result), 64'(0));
      check("rst/flags", 64'(flags), 64'(0));
      check("rst/illegal", 64'(illegal), 64'(0));
      check("rst/in_ready", 64'(in_ready), 64'(1));
      rst = 1'b0;
      tick();

      send("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 6'b011101, 1'b0, 0));
      collect("add_ovf");
      send("sub_zero", OP_SUB, 32'd5, 32'd5, mk(32'h0, 6'b001010, 1'b0, 0));
      collect("sub_zero");
      send("passb", OP_PASSB, 32'hDEAD_0000, 32'h1234, mk(32'h1234, 6'b001010, 1'b0, 0));
      collect("passb");
      send("asrn4", OP_ASRN, 32'h8000_0001, 32'd4, mk(32'hF800_0000, 6'b011100, 1'b0, 4));
      collect("asrn4");
      send("lsln31", OP_LSLN, 32'h1, 32'd31, mk(32'h8000_0000, 6'b011100, 1'b0, 31));
      collect("lsln31");
      send("lsln0", OP_LSLN, 32'h0000_ABCD, 32'd0, mk(32'h0000_ABCD, 6'b010000, 1'b0, 0));
      collect("lsln0");

      run("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h1);
      run("sub_borrow", OP_SUB, 32'd3, 32'd5);
      run("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1);
      run("inca_max", OP_INCA, 32'h7FFF_FFFF, 32'h0);
      run("deca_min", OP_DECA, 32'h8000_0000, 32'h0);
      run("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
      run("xor", OP_XOR, 32'h1234_5678, 32'h1234_5678);
      run("ornota", OP_ORNOTA, 32'hFFFF_0000, 32'h0000_00FF);
      run("asl", OP_ASL, 32'h4000_0001, 32'h0);
      run("lsr", OP_LSR, 32'h0000_0003, 32'h0);
      run("asln3", OP_ASLN, 32'h3000_0000, 32'd3);
      run("lsrn5", OP_LSRN, 32'hF000_0030, 32'd5);
      run("asrn1", OP_ASRN, 32'h7000_0001, 32'd1);

      // Output backpressure with a second op waiting at the input.
      out_ready = 1'b0;
      ex = model(OP_XOR, 32'hAAAA_0000, 32'h0F0F_0F0F);
      model_flags = ex.flg;
      ey = model(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
      model_flags = ey.flg;
      op = OP_XOR; a = 32'hAAAA_0000; b = 32'h0F0F_0F0F; in_valid = 1'b1;
      tick();
      op = OP_AND; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
      for (int i = 0; i < 3; i++) begin
         check("bp/out_valid", 64'(out_valid), 64'(1));
         check("bp/in_ready", 64'(in_ready), 64'(0));
         check("bp/result_hold", 64'(result), 64'(ex.res));
         check("bp/flags_hold", 64'(flags), 64'(ex.flg));
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp/in_ready_release", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      check("b2b/out_valid", 64'(out_valid), 64'(1));
      check("b2b/result", 64'(result), 64'(ey.res));
      check("b2b/flags", 64'(flags), 64'(ey.flg));
      tick();
      check("b2b/drain", 64'(out_valid), 64'(0));

      // Reset lands in the middle of a multi-bit shift.
      op = OP_LSRN; a = 32'hFFFF_0000; b = 32'd10; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("rst_mid/out_valid", 64'(out_valid), 64'(0));
      check("rst_mid/flags", 64'(flags), 64'(0));
      check("rst_mid/in_ready", 64'(in_ready), 64'(1));
      check("rst_mid/result", 64'(result), 64'(0));
      rst = 1'b0;
      model_flags = '0;
      ov_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) ov_seen = 1'b1;
      end
      check("rst_mid/no_stray_out", 64'(ov_seen), 64'(0));

      send("sub_pre_ill", OP_SUB, 32'd5, 32'd5, mk(32'h0, 6'b001010, 1'b0, 0));
      collect("sub_pre_ill");
      send("illegal", 6'h3F, 32'h1111_1111, 32'h2222_2222, mk(32'h0, 6'b001010, 1'b1, 0));
      collect("illegal");
      run("illegal_07", 6'h07, 32'h5, 32'h6);
      run("after_ill", OP_ADD, 32'd2, 32'd3);

      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
